// File: rtl/lut_neuron_table_dumper.sv
// Sweeps every neuron input code and packs the responses into WORD_W words; each word takes about E+LUT_LATENCY+2 cycles.
// Backpressure: m_ready low holds the output register, and issuing stalls once the next word is packed.
module lut_neuron_table_dumper #(
    parameter int IN_BITS     = 8,
    parameter int OUT_BITS    = 1,
    parameter int WORD_W      = 32,
    parameter int LUT_LATENCY = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [IN_BITS-1:0]  lut_in,
    input  logic [OUT_BITS-1:0] lut_out,
    output logic [WORD_W-1:0]   m_data,
    output logic                m_valid,
    output logic                m_last,
    input  logic                m_ready
);

    localparam int E      = WORD_W / OUT_BITS;
    localparam int SLOT_W = (E > 1) ? $clog2(E) : 1;
    localparam logic [IN_BITS:0]  TERM      = {1'b1, {IN_BITS{1'b0}}};
    localparam logic [IN_BITS:0]  LAST_ADDR = {1'b0, {IN_BITS{1'b1}}};
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(E - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_FLUSH, S_HANDOFF, S_FINISH} state_t;

    state_t              state_q, state_d;
    logic [IN_BITS:0]    addr_q, addr_d;
    logic [SLOT_W-1:0]   cnt_q, cnt_d;
    logic [IN_BITS-1:0]  hold_q, hold_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                done_q, done_d;

    logic                issue;
    logic                samp_vld;
    logic [SLOT_W-1:0]   samp_slot;
    logic                pend;

    // Tags follow each issued address until its response is due on lut_out.
    if (LUT_LATENCY == 0) begin : g_comb
        assign samp_vld  = issue;
        assign samp_slot = cnt_q;
        assign pend      = 1'b0;
    end else begin : g_pipe
        logic [LUT_LATENCY-1:0] vld_q, vld_d;
        logic [SLOT_W-1:0]      slot_q [LUT_LATENCY];
        logic [SLOT_W-1:0]      slot_d [LUT_LATENCY];

        always_comb begin
            vld_d[0]  = issue;
            slot_d[0] = cnt_q;
            for (int i = 1; i < LUT_LATENCY; i++) begin
                vld_d[i]  = vld_q[i-1];
                slot_d[i] = slot_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                for (int i = 0; i < LUT_LATENCY; i++) slot_q[i] <= '0;
            end else begin
                vld_q <= vld_d;
                for (int i = 0; i < LUT_LATENCY; i++) slot_q[i] <= slot_d[i];
            end
        end

        assign samp_vld  = vld_q[LUT_LATENCY-1];
        assign samp_slot = slot_q[LUT_LATENCY-1];
        assign pend      = |vld_d;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        pack_d  = pack_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        issue   = 1'b0;

        if (valid_q && m_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
        if (samp_vld) begin
            pack_d[int'(samp_slot)*OUT_BITS +: OUT_BITS] = lut_out;
        end

        case (state_q)
            S_IDLE: begin
                // The cycle done pulses is not a valid start cycle.
                if (start && !done_q) begin
                    state_d = S_ISSUE;
                    addr_d  = '0;
                    cnt_d   = '0;
                    pack_d  = '0;
                end
            end
            S_ISSUE: begin
                issue  = 1'b1;
                hold_d = addr_q[IN_BITS-1:0];
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_SLOT || addr_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!pend) state_d = S_HANDOFF;
            end
            S_HANDOFF: begin
                if (!valid_q || m_ready) begin
                    data_d  = pack_q;
                    valid_d = 1'b1;
                    last_d  = (addr_q == TERM);
                    pack_d  = '0;
                    state_d = (addr_q == TERM) ? S_FINISH : S_ISSUE;
                end
            end
            S_FINISH: begin
                if (valid_q && m_ready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            pack_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            pack_q  <= pack_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Outside ISSUE the neuron input rests on the last address driven.
    assign lut_in  = (state_q == S_ISSUE) ? addr_q[IN_BITS-1:0] : hold_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign m_data  = data_q;
    assign m_valid = valid_q;
    assign m_last  = last_q;

endmodule
